// File: rtl/spi_pkg.sv
// Shared types, default frame geometry and helpers for the serial ADC receiver.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_QUIET
  } spi_state_e;

  localparam int ADC_N_SCLK = 16;
  localparam int ADC_LEAD   = 3;
  localparam int ADC_DATA_W = 10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_adc_rx_clk_div.sv
// Tick generator: one-cycle o_tick every CLK_DIV enabled cycles, restartable by i_clr.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/spi_adc_rx.sv
// SPI master front end for a serial ADC: frames cs_n/sclk, samples miso on
// sclk rising edges and presents the data window with a one-cycle strobe.
module spi_adc_rx
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int N_SCLK    = ADC_N_SCLK,
  parameter int LEAD      = ADC_LEAD,
  parameter int DATA_W    = ADC_DATA_W,
  parameter int QUIET_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output spi_state_e        o_dbg_state
);

  localparam int EW = clog2(N_SCLK) + 1;
  localparam int QW = clog2(QUIET_CYC) + 1;

  if (LEAD + DATA_W > N_SCLK || CLK_DIV < 1 || QUIET_CYC < 1) begin : g_bad_params
    $error("spi_adc_rx: illegal parameter combination");
  end

  spi_state_e        r_state;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_shift;
  logic [EW-1:0]     r_edge_cnt;
  logic [QW-1:0]     r_quiet_cnt;

  logic              w_div_run;
  logic              w_tick;
  logic [EW-1:0]     w_edge_next;
  logic              w_in_window;

  assign w_div_run   = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_edge_next = r_edge_cnt + EW'(1);
  assign w_in_window = (w_edge_next > EW'(LEAD)) && (w_edge_next <= EW'(LEAD + DATA_W));

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_div_run),
    .i_clr (!w_div_run),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sclk      <= 1'b1;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_shift     <= '0;
      r_edge_cnt  <= '0;
      r_quiet_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_SETUP;
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_edge_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            // sclk currently low: this tick is a rising edge, so sample miso now
            if (!r_sclk) begin
              r_edge_cnt <= w_edge_next;
              if (w_in_window) r_shift <= {r_shift[DATA_W-2:0], miso};
              if (w_edge_next == EW'(N_SCLK)) r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_data      <= r_shift;
          r_valid     <= 1'b1;
          r_cs_n      <= 1'b1;
          r_quiet_cnt <= '0;
          r_state     <= ST_QUIET;
        end
        ST_QUIET: begin
          if (r_quiet_cnt == QW'(QUIET_CYC - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_quiet_cnt <= r_quiet_cnt + QW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sclk        = r_sclk;
  assign cs_n        = r_cs_n;
  assign data        = r_data;
  assign data_valid  = r_valid;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule
